// File: rtl/ram512_dma_if.sv
// Bus bundle between the DMA sequencer, its host/command side and the 512-word RAM.
interface ram512_dma_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   length;
  logic [DATA_W-1:0] fill_value;
  logic              host_load;
  logic [ADDR_W-1:0] host_address;
  logic [DATA_W-1:0] host_value;
  logic [DATA_W-1:0] ram_out;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_value;
  logic              busy;
  logic              done;

  // Sequencer side
  modport slave (
    input  start, mode, src_addr, dst_addr, length, fill_value,
    input  host_load, host_address, host_value, ram_out,
    output ram_load, ram_address, ram_value, busy, done
  );

  // Host/environment side
  modport master (
    output start, mode, src_addr, dst_addr, length, fill_value,
    output host_load, host_address, host_value, ram_out,
    input  ram_load, ram_address, ram_value, busy, done
  );
endinterface

// File: rtl/ram512_dma.sv
// Fill/copy sequencer in front of a 512-word RAM with one-cycle registered read.
// When idle the host port passes straight through to the RAM.
//
// state | meaning
// IDLE  | host owns the RAM, waiting for start
// FILL  | one pattern write per cycle at the destination pointer
// CP_RD | present the source address; RAM registers the word at the edge
// CP_WR | write the returned word to the destination pointer
module ram512_dma #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input logic        clk,
  input logic        reset,
  ram512_dma_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CP_RD, S_CP_WR} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   len_clamp;
  logic              ram_load;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_value;

  assign len_clamp = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;

  // State and captured-command registers; rem_q counts words still to write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and RAM port mux; pointers wrap naturally at 9 bits.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_d       = src_q;
    dst_d       = dst_q;
    fill_d      = fill_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    ram_load    = 1'b0;
    ram_address = dst_q;
    ram_value   = fill_q;

    unique case (state_q)
      S_IDLE: begin
        ram_load    = bus.host_load;
        ram_address = bus.host_address;
        ram_value   = bus.host_value;
        if (bus.start) begin
          mode_d = bus.mode;
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          fill_d = bus.fill_value;
          rem_d  = len_clamp;
          if (len_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = bus.mode ? S_CP_RD : S_FILL;
          end
        end
      end
      S_FILL: begin
        ram_load    = 1'b1;
        ram_address = dst_q;
        ram_value   = fill_q;
        dst_d       = dst_q + 1'b1;
        rem_d       = rem_q - 1'b1;
        if (rem_q == ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_CP_RD: begin
        ram_address = src_q;
        src_d       = src_q + 1'b1;
        state_d     = S_CP_WR;
      end
      S_CP_WR: begin
        ram_load    = 1'b1;
        ram_address = dst_q;
        ram_value   = bus.ram_out;
        dst_d       = dst_q + 1'b1;
        rem_d       = rem_q - 1'b1;
        if (rem_q == ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_CP_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // No write may slip through while reset is asserted.
    if (reset) ram_load = 1'b0;
  end

  assign bus.ram_load    = ram_load;
  assign bus.ram_address = ram_address;
  assign bus.ram_value   = ram_value;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_ram512_dma.sv
// Directed bench for ram512_dma with a behavioural 512x16 RAM (registered read).
module tb_ram512_dma;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram512_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram512_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:511];
  int wr_cnt = 0;

  // RAM model: registered read, write on ram_load, count every write.
  always @(posedge clk) begin
    bus.ram_out <= mem[bus.ram_address];
    if (bus.ram_load) begin
      mem[bus.ram_address] <= bus.ram_value;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bus.host_load    = 1'b1;
    bus.host_address = a;
    bus.host_value   = v;
    cyc();
    bus.host_load    = 1'b0;
  endtask

  task automatic hread(input logic [AW-1:0] a, output logic [DW-1:0] v);
    bus.host_load    = 1'b0;
    bus.host_address = a;
    cyc();
    v = bus.ram_out;
  endtask

  task automatic launch(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [AW:0] len, input logic [DW-1:0] f);
    bus.mode       = m;
    bus.src_addr   = s;
    bus.dst_addr   = d;
    bus.length     = len;
    bus.fill_value = f;
    bus.start      = 1'b1;
    cyc();
    bus.start      = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    int base;
    int n;

    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    bus.length = '0; bus.fill_value = '0;
    bus.host_load = 1'b1; bus.host_address = 9'h005; bus.host_value = 16'hFFFF;
    @(negedge clk);
    chk("rst_ram_load", 32'(bus.ram_load), 0);
    cyc(); cyc();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_no_write", wr_cnt, 0);
    cyc();
    reset = 1'b0;
    bus.host_load = 1'b0;

    hwrite(9'h014, 16'hBEEF);
    hwrite(9'h002, 16'h7777);
    hwrite(9'h020, 16'h1111);
    hwrite(9'h021, 16'h2222);
    hwrite(9'h022, 16'h3333);

    // Fill 4 words at 0x010
    base = wr_cnt;
    launch(1'b0, 9'h000, 9'h010, 10'd4, 16'hA5A5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fill_busy", 32'(bus.busy), 1);
      chk("fill_load", 32'(bus.ram_load), 1);
      chk("fill_addr", 32'(bus.ram_address), 32'h10 + i);
      chk("fill_value", 32'(bus.ram_value), 32'hA5A5);
      cyc();
    end
    @(negedge clk);
    chk("fill_done", 32'(bus.done), 1);
    chk("fill_busy_end", 32'(bus.busy), 0);
    cyc();
    @(negedge clk);
    chk("fill_done_single", 32'(bus.done), 0);
    chk("fill_wr_cnt", wr_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      hread(9'h010 + 9'(i), rd);
      chk("fill_readback", 32'(rd), 32'hA5A5);
    end
    hread(9'h014, rd);
    chk("fill_neighbour", 32'(rd), 32'hBEEF);

    // Copy 3 words 0x020 -> 0x100 while start and host writes are hammered
    base = wr_cnt;
    launch(1'b1, 9'h020, 9'h100, 10'd3, 16'h0000);
    bus.start = 1'b1; bus.mode = 1'b0; bus.src_addr = 9'h1F0; bus.dst_addr = 9'h000;
    bus.length = 10'd5; bus.fill_value = 16'hDEAD;
    bus.host_load = 1'b1; bus.host_address = 9'h021; bus.host_value = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("cp_rd_busy", 32'(bus.busy), 1);
      chk("cp_rd_load", 32'(bus.ram_load), 0);
      chk("cp_rd_addr", 32'(bus.ram_address), 32'h20 + k);
      cyc();
      @(negedge clk);
      chk("cp_wr_load", 32'(bus.ram_load), 1);
      chk("cp_wr_addr", 32'(bus.ram_address), 32'h100 + k);
      chk("cp_wr_value", 32'(bus.ram_value), 32'h1111 * (k + 1));
      cyc();
    end
    bus.start = 1'b0;
    bus.host_load = 1'b0;
    @(negedge clk);
    chk("cp_done", 32'(bus.done), 1);
    chk("cp_busy_end", 32'(bus.busy), 0);
    chk("cp_wr_cnt", wr_cnt - base, 3);
    for (int k = 0; k < 3; k++) begin
      hread(9'h100 + 9'(k), rd);
      chk("cp_readback", 32'(rd), 32'h1111 * (k + 1));
    end
    hread(9'h021, rd);
    chk("cp_src_intact", 32'(rd), 32'h2222);

    // Fill across the top of the address space
    base = wr_cnt;
    launch(1'b0, 9'h000, 9'h1FE, 10'd4, 16'h0F0F);
    for (int i = 0; i < 4; i++) begin
      a = 9'h1FE + 9'(i);
      @(negedge clk);
      chk("wrap_load", 32'(bus.ram_load), 1);
      chk("wrap_addr", 32'(bus.ram_address), 32'(a));
      cyc();
    end
    @(negedge clk);
    chk("wrap_done", 32'(bus.done), 1);
    chk("wrap_wr_cnt", wr_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      hread(9'h1FE + 9'(i), rd);
      chk("wrap_readback", 32'(rd), 32'h0F0F);
    end
    hread(9'h002, rd);
    chk("wrap_untouched", 32'(rd), 32'h7777);

    // Zero length
    base = wr_cnt;
    launch(1'b0, 9'h000, 9'h050, 10'd0, 16'h1234);
    @(negedge clk);
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_busy", 32'(bus.busy), 0);
    chk("zero_load", 32'(bus.ram_load), 0);
    cyc();
    @(negedge clk);
    chk("zero_done_single", 32'(bus.done), 0);
    chk("zero_busy2", 32'(bus.busy), 0);
    chk("zero_wr_cnt", wr_cnt - base, 0);

    // Length above 512 is clamped
    base = wr_cnt;
    launch(1'b0, 9'h000, 9'h000, 10'd700, 16'h5A5A);
    n = 0;
    while (!bus.done && n < 600) begin
      cyc();
      n++;
    end
    chk("big_done_seen", 32'(bus.done), 1);
    chk("big_cycles", n, 512);
    chk("big_wr_cnt", wr_cnt - base, 512);

    // Copy of 8 interrupted by reset after the third write
    for (int i = 0; i < 8; i++) hwrite(9'h040 + 9'(i), 16'h4000 + 16'(i));
    base = wr_cnt;
    launch(1'b1, 9'h040, 9'h140, 10'd8, 16'h0000);
    for (int i = 0; i < 6; i++) cyc();
    chk("mid_wr_cnt", wr_cnt - base, 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_done", 32'(bus.done), 0);
    cyc();
    @(negedge clk);
    chk("mid_no_late_done", 32'(bus.done), 0);
    chk("mid_wr_total", wr_cnt - base, 3);
    for (int i = 0; i < 8; i++) begin
      hread(9'h140 + 9'(i), rd);
      chk("mid_readback", 32'(rd), (i < 3) ? (32'h4000 + i) : 32'h5A5A);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
